// File: rtl/vga_pkg.sv
// Shared VGA timing constants, display-window bounds and the frame streamer FSM states.
// Both the streamer and the VGA controller import this package.
package vga_pkg;

  localparam int               PIX_W      = 6;
  localparam logic [9:0]       H_VIS      = 10'd640;
  localparam logic [9:0]       V_VIS      = 10'd480;
  localparam logic [9:0]       H_TOTAL    = 10'd800;
  localparam logic [9:0]       V_TOTAL    = 10'd525;
  localparam logic [9:0]       WIN_X_LO   = 10'd305;
  localparam logic [9:0]       WIN_X_HI   = 10'd334;
  localparam logic [9:0]       WIN_Y_LO   = 10'd225;
  localparam logic [9:0]       WIN_Y_HI   = 10'd254;
  localparam logic [PIX_W-1:0] BG_COLOR   = '0;
  localparam int               TILE_DEPTH = 900;
  localparam logic [9:0]       TILE_LAST  = 10'd899;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } stream_state_e;

  function automatic logic in_range(input logic [9:0] v,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Turns an asynchronous level into a single-cycle pulse in the clk domain.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  // Bits [1:0] are the synchronizer; bit [2] remembers the previous synchronized level.
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
    end
  end

  assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/vga_frame_streamer.sv
// Streams one visible frame per VGA request: tile RAM pixels inside the window, background elsewhere.
// Two-stage pipeline: stage 0 walks x/y and reads the RAM, stage 1 registers valid and muxes the pixel.
module vga_frame_streamer #(
  parameter int               PIX_W    = vga_pkg::PIX_W,
  parameter logic [9:0]       H_VIS    = vga_pkg::H_VIS,
  parameter logic [9:0]       V_VIS    = vga_pkg::V_VIS,
  parameter logic [9:0]       WIN_X_LO = vga_pkg::WIN_X_LO,
  parameter logic [9:0]       WIN_X_HI = vga_pkg::WIN_X_HI,
  parameter logic [9:0]       WIN_Y_LO = vga_pkg::WIN_Y_LO,
  parameter logic [9:0]       WIN_Y_HI = vga_pkg::WIN_Y_HI,
  parameter logic [PIX_W-1:0] BG_COLOR = '0
) (
  input  logic             clk_20,
  input  logic             reset_n,
  input  logic             fb_wr_en,
  input  logic [9:0]       fb_wr_addr,
  input  logic [PIX_W-1:0] fb_wr_data,
  output logic             fb_wr_ready,
  input  logic             vga_ready_in,
  output logic             vga_data_valid_out,
  output logic [PIX_W-1:0] vga_data_out,
  output logic             busy,
  output logic             frame_overrun
);

  import vga_pkg::*;

  localparam logic [9:0] X_LAST = H_VIS - 10'd1;
  localparam logic [9:0] Y_LAST = V_VIS - 10'd1;

  stream_state_e    state_q, state_d;
  logic             req_edge;
  logic             start_frame;
  logic             in_win;
  logic             frame_last;
  logic             wr_accept;
  logic [9:0]       x_q, y_q, rd_addr_q;
  logic             in_win_d;
  logic             valid_q;
  logic             overrun_q;
  logic [PIX_W-1:0] tile_ram [0:TILE_DEPTH-1];
  logic [PIX_W-1:0] rd_data_q;

  sync_edge u_req_sync (
    .clk      (clk_20),
    .rst_n    (reset_n),
    .async_in (vga_ready_in),
    .pulse    (req_edge)
  );

  assign in_win      = in_range(x_q, WIN_X_LO, WIN_X_HI) && in_range(y_q, WIN_Y_LO, WIN_Y_HI);
  assign frame_last  = (x_q == X_LAST) && (y_q == Y_LAST);
  assign start_frame = req_edge && (state_q == IDLE);
  assign wr_accept   = fb_wr_en && fb_wr_ready && (fb_wr_addr <= TILE_LAST);

  always_ff @(posedge clk_20 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fb_wr_ready = 1'b0;
    busy        = 1'b1;
    unique case (state_q)
      IDLE: begin
        fb_wr_ready = 1'b1;
        busy        = 1'b0;
        if (req_edge) state_d = STREAM;
      end
      STREAM: begin
        if (frame_last) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A request edge seen in STREAM or DRAIN is never started; it only latches the sticky overrun flag.
  always_ff @(posedge clk_20 or negedge reset_n) begin
    if (!reset_n) begin
      x_q       <= '0;
      y_q       <= '0;
      rd_addr_q <= '0;
      in_win_d  <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q  <= (state_q == STREAM);
      in_win_d <= (state_q == STREAM) && in_win;
      if (req_edge && (state_q != IDLE)) overrun_q <= 1'b1;
      if (start_frame) begin
        x_q       <= '0;
        y_q       <= '0;
        rd_addr_q <= '0;
      end else if (state_q == STREAM) begin
        if (in_win) rd_addr_q <= rd_addr_q + 10'd1;
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= y_q + 10'd1;
        end else begin
          x_q <= x_q + 10'd1;
        end
      end
    end
  end

  // Left unreset so synthesis maps it to block RAM with a registered read port.
  always_ff @(posedge clk_20) begin
    if (wr_accept) tile_ram[fb_wr_addr] <= fb_wr_data;
    rd_data_q <= tile_ram[rd_addr_q];
  end

  assign vga_data_valid_out = valid_q;
  assign vga_data_out       = in_win_d ? rd_data_q : BG_COLOR;
  assign frame_overrun      = overrun_q;

endmodule

// File: tb/tb_vga_frame_streamer.sv
// Directed self-checking bench for vga_frame_streamer, run on a shrunken 40x34 frame
// with the 30x30 window at columns 6..35, rows 2..31 so several whole frames stay short.
module tb_vga_frame_streamer;

  localparam int TB_H      = 40;
  localparam int TB_V      = 34;
  localparam int X_LO      = 6;
  localparam int X_HI      = 35;
  localparam int Y_LO      = 2;
  localparam int Y_HI      = 31;
  localparam int FRAME_PIX = TB_H * TB_V;

  logic       clk_20;
  logic       reset_n;
  logic       fb_wr_en;
  logic [9:0] fb_wr_addr;
  logic [5:0] fb_wr_data;
  logic       fb_wr_ready;
  logic       vga_ready_in;
  logic       vga_data_valid_out;
  logic [5:0] vga_data_out;
  logic       busy;
  logic       frame_overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Monitor state: pixels of the most recent valid run, its start cycle and length.
  logic [5:0] pix [0:FRAME_PIX-1];
  logic [5:0] exp_tile [0:899];
  logic       valid_prev    = 1'b0;
  int         run_len       = 0;
  int         last_len      = 0;
  int         run_start_cyc = 0;
  int         frames_done   = 0;
  int         raise_cyc     = 0;
  int         base_frames   = 0;

  vga_frame_streamer #(
    .PIX_W    (6),
    .H_VIS    (10'(TB_H)),
    .V_VIS    (10'(TB_V)),
    .WIN_X_LO (10'(X_LO)),
    .WIN_X_HI (10'(X_HI)),
    .WIN_Y_LO (10'(Y_LO)),
    .WIN_Y_HI (10'(Y_HI)),
    .BG_COLOR (6'd0)
  ) dut (
    .clk_20             (clk_20),
    .reset_n            (reset_n),
    .fb_wr_en           (fb_wr_en),
    .fb_wr_addr         (fb_wr_addr),
    .fb_wr_data         (fb_wr_data),
    .fb_wr_ready        (fb_wr_ready),
    .vga_ready_in       (vga_ready_in),
    .vga_data_valid_out (vga_data_valid_out),
    .vga_data_out       (vga_data_out),
    .busy               (busy),
    .frame_overrun      (frame_overrun)
  );

  initial clk_20 = 1'b0;
  always #25 clk_20 = ~clk_20;

  always @(posedge clk_20) cyc <= cyc + 1;

  // Records each contiguous valid run; a falling valid closes one run (one frame or an aborted one).
  always @(negedge clk_20) begin
    if (vga_data_valid_out) begin
      if (!valid_prev) begin
        run_len       = 0;
        run_start_cyc = cyc;
      end
      if (run_len < FRAME_PIX) pix[run_len] = vga_data_out;
      run_len++;
    end else if (valid_prev) begin
      frames_done++;
      last_len = run_len;
    end
    valid_prev = vga_data_valid_out;
  end

  task automatic applyStimulus(input logic we, input logic [9:0] addr,
                               input logic [5:0] data, input logic req);
    fb_wr_en     = we;
    fb_wr_addr   = addr;
    fb_wr_data   = data;
    vga_ready_in = req;
    @(posedge clk_20);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 10'd0, 6'd0, 1'b0);
  endtask

  task automatic waitFrames(input int target, input string tag);
    int budget;
    budget = 5000;
    while (frames_done < target && budget > 0) begin
      applyStimulus(1'b0, 10'd0, 6'd0, 1'b0);
      budget--;
    end
    checkOutput(tag, int'(frames_done >= target), 1);
  endtask

  function automatic int pixAt(input int x, input int y);
    return int'(pix[y * TB_H + x]);
  endfunction

  function automatic int countPixelErrors();
    int errs;
    errs = 0;
    for (int y = 0; y < TB_V; y++) begin
      for (int x = 0; x < TB_H; x++) begin
        logic [5:0] e;
        e = 6'd0;
        if (x >= X_LO && x <= X_HI && y >= Y_LO && y <= Y_HI)
          e = exp_tile[(y - Y_LO) * 30 + (x - X_LO)];
        if (pix[y * TB_H + x] !== e) errs++;
      end
    end
    return errs;
  endfunction

  initial begin
    reset_n      = 1'b0;
    fb_wr_en     = 1'b0;
    fb_wr_addr   = '0;
    fb_wr_data   = '0;
    vga_ready_in = 1'b0;
    repeat (3) @(posedge clk_20);
    #1;
    checkOutput("reset valid", int'(vga_data_valid_out), 0);
    checkOutput("reset data", int'(vga_data_out), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset overrun", int'(frame_overrun), 0);
    checkOutput("reset wr_ready", int'(fb_wr_ready), 1);
    reset_n = 1'b1;
    idleCycles(2);

    // Load the tile with (k mod 63)+1, then an out-of-range write that must be dropped.
    for (int k = 0; k < 900; k++) begin
      exp_tile[k] = 6'((k % 63) + 1);
      applyStimulus(1'b1, 10'(k), 6'((k % 63) + 1), 1'b0);
    end
    applyStimulus(1'b1, 10'd950, 6'd7, 1'b0);
    idleCycles(2);

    // Frame 1: three-cycle request pulse.
    raise_cyc = cyc;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 10'd0, 6'd0, 1'b1);
    waitFrames(1, "frame1 done");
    checkOutput("frame1 latency", run_start_cyc - raise_cyc, 4);
    checkOutput("frame1 length", last_len, FRAME_PIX);
    checkOutput("frame1 win first", pixAt(X_LO, Y_LO), 1);
    checkOutput("frame1 win last", pixAt(X_HI, Y_HI), 18);
    checkOutput("frame1 left of win", pixAt(X_LO - 1, Y_LO), 0);
    checkOutput("frame1 origin", pixAt(0, 0), 0);
    checkOutput("frame1 all pixels", countPixelErrors(), 0);
    checkOutput("frame1 overrun", int'(frame_overrun), 0);
    idleCycles(5);

    // Frame 2: writes held during STREAM and a second request 1000 cycles in.
    for (int i = 0; i < 1100; i++) begin
      applyStimulus((i >= 100 && i < 110), 10'd0, 6'd5,
                    (i < 3) || (i >= 1000 && i < 1003));
      if (i == 105) begin
        checkOutput("stream wr_ready", int'(fb_wr_ready), 0);
        checkOutput("stream busy", int'(busy), 1);
      end
    end
    checkOutput("overrun set", int'(frame_overrun), 1);
    waitFrames(2, "frame2 done");
    checkOutput("frame2 length", last_len, FRAME_PIX);
    checkOutput("frame2 all pixels", countPixelErrors(), 0);
    idleCycles(300);
    checkOutput("no extra frame", frames_done, 2);
    checkOutput("idle busy", int'(busy), 0);
    checkOutput("overrun sticky", int'(frame_overrun), 1);

    // Frame 3: abandoned by reset 500 cycles into the stream.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 10'd0, 6'd0, 1'b1);
    idleCycles(500);
    checkOutput("pre-reset valid", int'(vga_data_valid_out), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset valid", int'(vga_data_valid_out), 0);
    checkOutput("midreset busy", int'(busy), 0);
    checkOutput("midreset overrun", int'(frame_overrun), 0);
    idleCycles(3);
    reset_n = 1'b1;
    idleCycles(3);
    checkOutput("aborted run counted", frames_done, 3);

    // Frame 4: a write lands in the very cycle the FSM leaves IDLE.
    raise_cyc = cyc;
    applyStimulus(1'b0, 10'd0, 6'd0, 1'b1);
    applyStimulus(1'b0, 10'd0, 6'd0, 1'b1);
    applyStimulus(1'b1, 10'd1, 6'd40, 1'b1);
    exp_tile[1] = 6'd40;
    checkOutput("frame4 busy", int'(busy), 1);
    waitFrames(4, "frame4 done");
    checkOutput("frame4 latency", run_start_cyc - raise_cyc, 4);
    checkOutput("frame4 length", last_len, FRAME_PIX);
    checkOutput("frame4 addr0 kept", pixAt(X_LO, Y_LO), 1);
    checkOutput("frame4 edge write", pixAt(X_LO + 1, Y_LO), 40);
    checkOutput("frame4 all pixels", countPixelErrors(), 0);
    idleCycles(5);

    // Frame 5: request level held high for 10000 cycles.
    base_frames = frames_done;
    raise_cyc   = cyc;
    for (int i = 0; i < 10000; i++) applyStimulus(1'b0, 10'd0, 6'd0, 1'b1);
    applyStimulus(1'b0, 10'd0, 6'd0, 1'b0);
    idleCycles(20);
    checkOutput("held req one frame", frames_done - base_frames, 1);
    checkOutput("held req latency", run_start_cyc - raise_cyc, 4);
    checkOutput("held req length", last_len, FRAME_PIX);
    checkOutput("held req overrun", int'(frame_overrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
